mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates a single-port, synchronous-read memory between the CPU's instruction-fetch port (I) and load/store port (D), enabling a unified instruction/data memory behind the MIPS core. Grants one requester per cycle, drives the memory port combinationally, tracks the owner of the in-flight read and returns read data one cycle later. Also maintains a saturating conflict counter for performance visibility.

## Interface
- AW, 32, address width (byte address, passed through unchanged)
- DW, 32, data width
- STARVE_LIMIT, 4, consecutive I-port denials before forced I grant (≥1; used only with ARB_ANTISTARVE_EN)

- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- i_req  input  1  fetch request; held with i_addr until i_gnt
- i_addr  input  AW  fetch address
- i_gnt  output  1  fetch accepted this cycle (combinational)
- i_rvalid  output  1  i_rdata valid (registered)
- i_rdata  output  DW  fetch data
- d_req  input  1  load/store request; held with payload until d_gnt
- d_we  input  4  byte write enables; 4'b0000 = read
- d_addr  input  AW  data address
- d_wdata  input  DW  store data
- d_gnt  output  1  data access accepted this cycle (combinational)
- d_rvalid  output  1  d_rdata valid (registered)
- d_rdata  output  DW  load data
- mem_en  output  1  memory enable
- mem_we  output  4  memory byte write enables
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data, valid one cycle after enable
- conflict_cnt  output  32  saturating count of cycles with i_req & d_req both high

## Operation
- Grant (combinational): only d_req → D; only i_req → I; both → D, unless anti-starvation forces I (see Configuration). Neither → mem_en=0.
- Exactly one of i_gnt/d_gnt high per cycle; never both.
- Memory mux: mem_en = i_gnt|d_gnt; mem_addr/mem_we/mem_wdata from the granted port; I grant drives mem_we=0, mem_wdata=0. Idle drives all mem_* to 0.
- Read owner register rd_own ∈ {OWN_NONE, OWN_I, OWN_D}: next = OWN_I on i_gnt; OWN_D on d_gnt with d_we==0; else OWN_NONE.
- i_rvalid = (rd_own==OWN_I); d_rvalid = (rd_own==OWN_D). i_rdata/d_rdata = mem_rdata when own valid, else 0.
- Stores: write completes in grant cycle; no rvalid ever generated.
- conflict_cnt increments each cycle i_req & d_req, saturates at 32'hFFFF_FFFF.
- Requester dropping req before grant: legal, no side effect.
- rst low (any time, including with a read in flight): rd_own=OWN_NONE, conflict_cnt=0, starvation counter=0, all outputs 0 (grants and mem_en forced 0 while rst low). In-flight read data is discarded.

## Timing
- Grant latency 0: request seen and granted in cycle N, memory samples at end of N.
- Read data latency 1: rvalid and rdata in cycle N+1 only (single-cycle pulse per grant).
- Back-to-back grants fully pipelined: a grant in N+1 coexists with rvalid from N.
- Contended I access waits ≥1 cycle; with anti-starvation, at most STARVE_LIMIT cycles.
- Reset values: all outputs 0.

## Configuration
- ARB_ANTISTARVE_EN defined: wait counter (width $clog2(STARVE_LIMIT+1)) increments each cycle i_req & ~i_gnt, clears on i_gnt or ~i_req; when counter==STARVE_LIMIT, I wins even if d_req is high.
- Undefined: strict D-over-I priority, no counter; I can starve indefinitely under continuous d_req.

## Structure
- Package arb_pkg: owner enum (OWN_NONE, OWN_I, OWN_D), WE_READ=4'b0000 constant, conflict counter width.
- One sub-module arb_starve_cnt (wait counter plus force-I flag), instantiated only under ARB_ANTISTARVE_EN.

## Test plan
- Reset: rst=0 with both reqs high → all outputs 0, conflict_cnt=0; release rst → normal grants next cycle.
- I-only read i_addr=0x10 → i_gnt=1, mem_addr=0x10, mem_we=0 same cycle; next cycle i_rvalid=1, i_rdata=mem_rdata, d_rvalid=0.
- Contention: i_req+d_req read d_addr=0x50 in cycle N → d_gnt at N, i_gnt at N+1, d_rvalid at N+1, i_rvalid at N+2, conflict_cnt=1.
- Store d_we=4'hF, d_addr=84, d_wdata=7 → mem_we=4'hF, mem_addr=84, mem_wdata=7 in grant cycle; d_rvalid stays 0.
- Starvation, STARVE_LIMIT=4, d_req and i_req held 10 cycles: with macro → i_gnt in cycle 5, then D resumes; without macro → i_gnt never asserts, conflict_cnt=10.
- Reset mid-read: rst low the cycle after a d read grant → d_rvalid=0 and stays 0 after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// arb_pkg: shared types and constants for the I/D memory port arbiter.
package arb_pkg;

  // Which requester owns the read whose data returns next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } own_e;

  // A D-port access with no byte enables set is a load.
  localparam logic [3:0] WE_READ = 4'b0000;

  // Width and ceiling of the contention performance counter.
  localparam int                    CONFLICT_W   = 32;
  localparam logic [CONFLICT_W-1:0] CONFLICT_MAX = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch port, load/store port and memory port of the
// unified-memory arbiter. The arbiter uses the slave view; the core and
// the memory together form the master side.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Instruction-fetch port
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  // Load/store port
  logic          d_req;
  logic [3:0]    d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  // Single-port synchronous-read memory
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_starve_cnt.sv
// arb_starve_cnt: counts consecutive cycles the fetch port has been kept
// waiting and raises force_i once that reaches STARVE_LIMIT, so the next
// fetch wins over a load/store.
module arb_starve_cnt #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  output logic force_i
);
  localparam int                WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] LIMIT  = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] wait_cnt;

  // Count denied fetch cycles; a grant or a withdrawn request starts over.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (i_req && !i_gnt) begin
      wait_cnt <= (wait_cnt == LIMIT) ? wait_cnt : wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign force_i = rst && (wait_cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous-read memory between
// the instruction-fetch (I) and load/store (D) ports of the core. One
// requester is granted per cycle (D preferred), the memory port is driven
// combinationally from the winner, and read data is routed back one cycle
// later to whichever port issued the read. conflict_cnt saturates.
// Build option: define ARB_ANTISTARVE_EN to bound how long a contended
// fetch can wait (STARVE_LIMIT cycles); otherwise D has strict priority.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.slave     bus,
  output logic [CONFLICT_W-1:0] conflict_cnt
);

  function automatic logic [CONFLICT_W-1:0] sat_inc(input logic [CONFLICT_W-1:0] v);
    return (v == CONFLICT_MAX) ? v : v + 1'b1;
  endfunction

  logic          force_i;
  logic          i_gnt;
  logic          d_gnt;
  logic          d_is_read;
  own_e          rd_own;
  own_e          rd_own_nxt;
  logic [AW-1:0] addr_sel;
  logic [3:0]    we_sel;
  logic [DW-1:0] wdata_sel;

`ifdef ARB_ANTISTARVE_EN
  arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .i_req  (bus.i_req),
    .i_gnt  (i_gnt),
    .force_i(force_i)
  );
`else
  // Without anti-starvation the limit has no effect on the hardware.
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign force_i = 1'b0;
`endif

  assign d_is_read = (bus.d_we == WE_READ);

  // Pick the winner: D unless a starved fetch is being forced; nothing in reset.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst) begin
      if (bus.d_req && !(bus.i_req && force_i)) begin
        d_gnt = 1'b1;
      end else if (bus.i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  // Steer the winner's address and store payload onto the memory port.
  always_comb begin
    addr_sel  = '0;
    we_sel    = WE_READ;
    wdata_sel = '0;
    if (d_gnt) begin
      addr_sel  = bus.d_addr;
      we_sel    = bus.d_we;
      wdata_sel = bus.d_wdata;
    end else if (i_gnt) begin
      addr_sel  = bus.i_addr;
    end
  end

  // Remember who issued a read this cycle; stores produce no response.
  always_comb begin
    rd_own_nxt = OWN_NONE;
    if (i_gnt) begin
      rd_own_nxt = OWN_I;
    end else if (d_gnt && d_is_read) begin
      rd_own_nxt = OWN_D;
    end
  end

  // ---- stage boundary: grant cycle -> read-data return cycle ----
  // Owner of the read in flight; reset discards any pending response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_own <= OWN_NONE;
    end else begin
      rd_own <= rd_own_nxt;
    end
  end

  // Count cycles in which both ports want the memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= '0;
    end else if (bus.i_req && bus.d_req) begin
      conflict_cnt <= sat_inc(conflict_cnt);
    end
  end

  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = i_gnt | d_gnt;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_we    = we_sel;
  assign bus.mem_wdata = wdata_sel;

  assign bus.i_rvalid  = (rd_own == OWN_I);
  assign bus.d_rvalid  = (rd_own == OWN_D);
  assign bus.i_rdata   = (rd_own == OWN_I) ? bus.mem_rdata : '0;
  assign bus.d_rdata   = (rd_own == OWN_D) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed stimulus for the I/D memory
// arbiter, with a behavioural reference model and a small word memory
// attached to the arbiter's memory port.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] conflict_cnt;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW          (AW),
    .DW          (DW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int k);
    return 32'hA5A5_0000 ^ (k * 32'h0101_0103);
  endfunction

  // Memory behind the arbiter: 64 words, synchronous read, byte writes.
  logic [31:0] mem [64];
  logic [31:0] rd_q      = 32'hDEAD_BEEF;
  logic        mem_ready = 1'b0;
  assign bus.mem_rdata = rd_q;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < 64; k++) mem[k] <= pat(k);
      mem_ready <= 1'b1;
    end else if (bus.mem_en) begin
      rd_q <= mem[bus.mem_addr[7:2]];
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: shadow memory, pending read, counters.
  logic [31:0] sm [64];
  int          m_own;     // 0 none, 1 fetch, 2 load
  logic [31:0] m_pend;
  longint      m_conf;
  int          m_wait;
  logic        m_force, m_gi, m_gd;

  initial begin
    for (int k = 0; k < 64; k++) sm[k] = pat(k);
    m_own = 0; m_pend = '0; m_conf = 0; m_wait = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_own = 0; m_conf = 0; m_wait = 0;
        chk("rst_i_gnt", bus.i_gnt, 0);       chk("rst_d_gnt", bus.d_gnt, 0);
        chk("rst_mem_en", bus.mem_en, 0);     chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0); chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_i_rvalid", bus.i_rvalid, 0); chk("rst_d_rvalid", bus.d_rvalid, 0);
        chk("rst_i_rdata", bus.i_rdata, 0);   chk("rst_d_rdata", bus.d_rdata, 0);
        chk("rst_conflict", conflict_cnt, 0);
      end else begin
        m_force = 1'b0;
`ifdef ARB_ANTISTARVE_EN
        m_force = (m_wait >= SL);
`endif
        m_gd = bus.d_req && !(bus.i_req && m_force);
        m_gi = bus.i_req && !m_gd;
        chk("m_i_gnt", bus.i_gnt, m_gi);
        chk("m_d_gnt", bus.d_gnt, m_gd);
        chk("m_mem_en", bus.mem_en, m_gi | m_gd);
        chk("m_mem_addr", bus.mem_addr, m_gd ? bus.d_addr : (m_gi ? bus.i_addr : 32'h0));
        chk("m_mem_we", bus.mem_we, m_gd ? bus.d_we : 4'h0);
        chk("m_mem_wdata", bus.mem_wdata, m_gd ? bus.d_wdata : 32'h0);
        chk("m_i_rvalid", bus.i_rvalid, m_own == 1);
        chk("m_d_rvalid", bus.d_rvalid, m_own == 2);
        chk("m_i_rdata", bus.i_rdata, (m_own == 1) ? m_pend : 32'h0);
        chk("m_d_rdata", bus.d_rdata, (m_own == 2) ? m_pend : 32'h0);
        chk("m_conflict", conflict_cnt, m_conf[31:0]);
        // Advance model state to what holds after the coming clock edge.
        if (bus.i_req && bus.d_req && m_conf < 64'hFFFF_FFFF) m_conf++;
        m_wait = (bus.i_req && !m_gi) ? m_wait + 1 : 0;
        m_own  = 0;
        if (m_gi) begin
          m_own = 1; m_pend = sm[bus.i_addr[7:2]];
        end else if (m_gd && bus.d_we == 4'h0) begin
          m_own = 2; m_pend = sm[bus.d_addr[7:2]];
        end else if (m_gd) begin
          for (int b = 0; b < 4; b++)
            if (bus.d_we[b]) sm[bus.d_addr[7:2]][8*b +: 8] = bus.d_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic idle();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 4'h0; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  logic       s_ig, s_dg;
  logic [9:0] gv, dv;

  initial begin
    idle();
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    // Reset held with both requests up: everything quiet.
    @(negedge clk);
    chk("reset_i_gnt", bus.i_gnt, 0);
    chk("reset_d_gnt", bus.d_gnt, 0);
    chk("reset_mem_en", bus.mem_en, 0);
    chk("reset_conflict", conflict_cnt, 0);
    @(negedge clk);

    // Fetch-only read of 0x10.
    step(); rst = 1'b1; idle(); bus.i_req = 1'b1; bus.i_addr = 32'h10;
    @(negedge clk);
    chk("iread_i_gnt", bus.i_gnt, 1);
    chk("iread_mem_addr", bus.mem_addr, 32'h10);
    chk("iread_mem_we", bus.mem_we, 0);
    step(); idle();
    @(negedge clk);
    chk("iread_i_rvalid", bus.i_rvalid, 1);
    chk("iread_i_rdata", bus.i_rdata, pat(4));
    chk("iread_d_rvalid", bus.d_rvalid, 0);

    // Contention: load of 0x50 wins, fetch of 0x20 follows.
    step(); rst = 1'b0;
    step(); rst = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h20;
    bus.d_req = 1'b1; bus.d_we = 4'h0; bus.d_addr = 32'h50;
    @(negedge clk);
    chk("cont_d_gnt", bus.d_gnt, 1);
    chk("cont_i_gnt_n", bus.i_gnt, 0);
    step(); bus.d_req = 1'b0;
    @(negedge clk);
    chk("cont_i_gnt_n1", bus.i_gnt, 1);
    chk("cont_d_rvalid", bus.d_rvalid, 1);
    chk("cont_d_rdata", bus.d_rdata, pat(20));
    chk("cont_conflict", conflict_cnt, 1);
    step(); idle();
    @(negedge clk);
    chk("cont_i_rvalid", bus.i_rvalid, 1);
    chk("cont_i_rdata", bus.i_rdata, pat(8));

    // Store of 7 to byte address 84, then read it back over the fetch port.
    step(); bus.d_req = 1'b1; bus.d_we = 4'hF; bus.d_addr = 32'd84; bus.d_wdata = 32'd7;
    @(negedge clk);
    chk("st_mem_we", bus.mem_we, 4'hF);
    chk("st_mem_addr", bus.mem_addr, 32'd84);
    chk("st_mem_wdata", bus.mem_wdata, 32'd7);
    step(); idle();
    @(negedge clk);
    chk("st_d_rvalid", bus.d_rvalid, 0);
    step(); bus.i_req = 1'b1; bus.i_addr = 32'd84;
    @(negedge clk);
    step(); idle();
    @(negedge clk);
    chk("st_readback", bus.i_rdata, 32'd7);

    // Both ports requesting for ten cycles.
    step(); rst = 1'b0;
    step(); rst = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h30;
    bus.d_req = 1'b1; bus.d_we = 4'h0; bus.d_addr = 32'h40;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      gv[c] = bus.i_gnt; dv[c] = bus.d_gnt;
      step();
      if (c == 9) idle();
      else begin bus.d_addr = 32'h40 + 32'(4 * c); if (gv[c]) bus.i_addr = bus.i_addr + 32'h4; end
    end
    @(negedge clk);
`ifdef ARB_ANTISTARVE_EN
    chk("starve_i_gnts", 32'(gv), 32'h210);
    chk("starve_d_gnts", 32'(dv), 32'h1EF);
`else
    chk("starve_i_gnts", 32'(gv), 32'h000);
    chk("starve_d_gnts", 32'(dv), 32'h3FF);
`endif
    chk("starve_conflict", conflict_cnt, 10);

    // Reset arriving while a load is in flight.
    step(); bus.d_req = 1'b1; bus.d_we = 4'h0; bus.d_addr = 32'h60;
    @(negedge clk);
    chk("rmid_d_gnt", bus.d_gnt, 1);
    step(); rst = 1'b0; idle();
    @(negedge clk);
    chk("rmid_d_rvalid_low", bus.d_rvalid, 0);
    step(); rst = 1'b1;
    @(negedge clk);
    chk("rmid_d_rvalid_after", bus.d_rvalid, 0);

    // Random traffic: requests hold until granted, occasionally withdrawn.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      s_ig = bus.i_gnt; s_dg = bus.d_gnt;
      step();
      if (c == 2000) rst = 1'b0;
      if (c == 2003) rst = 1'b1;
      if (!(bus.i_req && !s_ig && $urandom_range(0, 15) != 0)) begin
        bus.i_req  = ($urandom_range(0, 9) < 7);
        bus.i_addr = $urandom;
      end
      if (!(bus.d_req && !s_dg && $urandom_range(0, 15) != 0)) begin
        bus.d_req   = ($urandom_range(0, 9) < 7);
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
        bus.d_we    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      end
    end
    step(); idle();
    @(negedge clk);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
